// File: rtl/nios_mtl_sysid_pkg.sv
// Shared register map, CTRL bit positions and byte-merge helper for the
// extended system-ID slave.
package nios_mtl_sysid_pkg;

  localparam int unsigned OFF_ID        = 0;
  localparam int unsigned OFF_TIMESTAMP = 1;
  localparam int unsigned OFF_CLK_HZ    = 2;
  localparam int unsigned OFF_SCRATCH   = 3;
  localparam int unsigned OFF_UPTIME_LO = 4;
  localparam int unsigned OFF_UPTIME_HI = 5;
  localparam int unsigned OFF_CTRL      = 6;
  localparam int unsigned OFF_NUM_USER  = 7;
  localparam int unsigned USER_BASE     = 8;

  localparam int unsigned CTRL_RUN   = 0;
  localparam int unsigned CTRL_CLEAR = 1;
  localparam int unsigned CTRL_SNAP  = 8;

  function automatic logic [31:0] byte_merge(input logic [31:0] old_word,
                                             input logic [31:0] new_word,
                                             input logic [3:0]  lanes);
    logic [31:0] merged;
    merged = old_word;
    for (int b = 0; b < 4; b++)
      if (lanes[b]) merged[8*b +: 8] = new_word[8*b +: 8];
    return merged;
  endfunction

endpackage

// File: rtl/nios_mtl_sysid_uptime.sv
// 64-bit free-running uptime counter with a high-word snapshot that lets
// software read the full value coherently as LO then HI.
module nios_mtl_sysid_uptime (
  input  logic        clock,
  input  logic        reset,
  input  logic        run,
  input  logic        clear,
  input  logic        latch,
  input  logic        unlatch,
  output logic [31:0] count_lo,
  output logic [31:0] snapshot,
  output logic        snap_valid
);

  logic [63:0] cnt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset)      cnt <= '0;
    else if (clear) cnt <= '0;
    else if (run)   cnt <= cnt + 64'd1;
  end

  // Clear has priority so a LO read coincident with CLEAR still leaves a zero snapshot.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      snapshot   <= '0;
      snap_valid <= 1'b0;
    end else if (clear) begin
      snapshot   <= '0;
      snap_valid <= 1'b0;
    end else if (latch) begin
      snapshot   <= cnt[63:32];
      snap_valid <= 1'b1;
    end else if (unlatch) begin
      snap_valid <= 1'b0;
    end
  end

  assign count_lo = cnt[31:0];

endmodule

// File: rtl/nios_mtl_sysid_ext.sv
// Avalon-MM system-identification slave: constant ID words, scratch
// register, run/clear control, uptime counter and user info table.
module nios_mtl_sysid_ext
  import nios_mtl_sysid_pkg::*;
#(
  parameter logic [31:0]            ID_VALUE   = 32'd1459509197,
  parameter logic [31:0]            TIMESTAMP  = 32'd0,
  parameter int unsigned            CLK_HZ     = 50_000_000,
  parameter int unsigned            NUM_USER   = 4,
  parameter logic [32*NUM_USER-1:0] USER_WORDS = '0,
  parameter int unsigned            ADDR_W     = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] address,
  input  logic              read,
  input  logic              write,
  input  logic [31:0]       writedata,
  input  logic [3:0]        byteenable,
  output logic [31:0]       readdata,
  output logic              readdatavalid
);

  if ((NUM_USER < 1) || (USER_BASE + NUM_USER > (1 << ADDR_W))) begin : g_map_check
    $error("nios_mtl_sysid_ext: user table does not fit in the address space");
  end

  logic [31:0] addr_w;
  logic [31:0] scratch;
  logic        run;
  logic        wr_ctrl;
  logic        clear;
  logic        rd_lo;
  logic        rd_hi;
  logic [31:0] count_lo;
  logic [31:0] snapshot;
  logic        snap_valid;
  logic [31:0] rd_data;

  assign addr_w  = 32'(address);
  assign wr_ctrl = write && (addr_w == OFF_CTRL) && byteenable[0];
  assign clear   = wr_ctrl && writedata[CTRL_CLEAR];
  assign rd_lo   = read && (addr_w == OFF_UPTIME_LO);
  assign rd_hi   = read && (addr_w == OFF_UPTIME_HI);

  nios_mtl_sysid_uptime u_uptime (
    .clock      (clock),
    .reset      (reset),
    .run        (run),
    .clear      (clear),
    .latch      (rd_lo),
    .unlatch    (rd_hi),
    .count_lo   (count_lo),
    .snapshot   (snapshot),
    .snap_valid (snap_valid)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      scratch <= '0;
      run     <= 1'b1;
    end else begin
      if (write && (addr_w == OFF_SCRATCH))
        scratch <= byte_merge(scratch, writedata, byteenable);
      if (wr_ctrl)
        run <= writedata[CTRL_RUN];
    end
  end

  // Read mux works on pre-edge state, so a simultaneous write is not visible here.
  always_comb begin
    rd_data = '0;
    case (addr_w)
      OFF_ID:        rd_data = ID_VALUE;
      OFF_TIMESTAMP: rd_data = TIMESTAMP;
      OFF_CLK_HZ:    rd_data = CLK_HZ;
      OFF_SCRATCH:   rd_data = scratch;
      OFF_UPTIME_LO: rd_data = count_lo;
      OFF_UPTIME_HI: rd_data = snapshot;
      OFF_CTRL: begin
        rd_data[CTRL_RUN]  = run;
        rd_data[CTRL_SNAP] = snap_valid;
      end
      OFF_NUM_USER:  rd_data = NUM_USER;
      default: begin
        for (int k = 0; k < int'(NUM_USER); k++)
          if (addr_w == USER_BASE + 32'(k))
            rd_data = USER_WORDS[32*k +: 32];
      end
    endcase
  end

  // Response stage: data and strobe one cycle after the read request.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      readdata      <= '0;
      readdatavalid <= 1'b0;
    end else begin
      readdatavalid <= read;
      if (read) readdata <= rd_data;
    end
  end

endmodule

// File: tb/tb_nios_mtl_sysid_ext.sv
// Directed self-checking bench for the extended system-ID slave.
module tb_nios_mtl_sysid_ext;

  localparam logic [31:0]  TS    = 32'h6543_2100;
  localparam logic [127:0] UWORD = {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111};

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  address = '0;
  logic        read = 1'b0;
  logic        write = 1'b0;
  logic [31:0] writedata = '0;
  logic [3:0]  byteenable = '0;
  logic [31:0] readdata;
  logic        readdatavalid;

  int checks = 0;
  int errors = 0;

  nios_mtl_sysid_ext #(
    .ID_VALUE   (32'd1459509197),
    .TIMESTAMP  (TS),
    .CLK_HZ     (50_000_000),
    .NUM_USER   (4),
    .USER_WORDS (UWORD),
    .ADDR_W     (4)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .address       (address),
    .read          (read),
    .write         (write),
    .writedata     (writedata),
    .byteenable    (byteenable),
    .readdata      (readdata),
    .readdatavalid (readdatavalid)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic rd(input logic [3:0] a, output logic [31:0] d);
    @(negedge clock);
    address = a;
    read    = 1'b1;
    @(negedge clock);
    read = 1'b0;
    check("rdvalid", 32'(readdatavalid), 32'd1);
    d = readdata;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
    @(negedge clock);
    address    = a;
    writedata  = d;
    byteenable = be;
    write      = 1'b1;
    @(negedge clock);
    write = 1'b0;
  endtask

  logic [31:0] d, d1, d2;

  initial begin
    repeat (3) @(negedge clock);
    check("reset_rdata", readdata, 32'h0);
    check("reset_rdv", 32'(readdatavalid), 32'd0);
    reset = 1'b0;

    rd(4'd0, d); check("id", d, 32'd1459509197);
    rd(4'd1, d); check("timestamp", d, TS);
    rd(4'd2, d); check("clk_hz", d, 32'd50_000_000);
    rd(4'd7, d); check("num_user", d, 32'd4);
    @(negedge clock);
    check("rdv_one_cycle", 32'(readdatavalid), 32'd0);
    rd(4'd3, d); check("scratch_reset", d, 32'h0);
    rd(4'd6, d); check("ctrl_reset", d, 32'h1);

    // Back-to-back reads
    @(negedge clock); address = 4'd0; read = 1'b1;
    @(negedge clock); address = 4'd2;
    check("b2b_v0", 32'(readdatavalid), 32'd1); check("b2b_d0", readdata, 32'd1459509197);
    @(negedge clock); read = 1'b0;
    check("b2b_v1", 32'(readdatavalid), 32'd1); check("b2b_d1", readdata, 32'd50_000_000);

    // Scratch byte lanes and readdata hold
    wr(4'd3, 32'hDEAD_BEEF, 4'hF);
    wr(4'd3, 32'h0000_0000, 4'b0101);
    rd(4'd3, d); check("scratch_be", d, 32'hDE00_BE00);
    repeat (3) @(negedge clock);
    check("hold_rdata", readdata, 32'hDE00_BE00);
    check("hold_rdv", 32'(readdatavalid), 32'd0);

    // Read and write together: read sees pre-write value
    @(negedge clock);
    address = 4'd3; writedata = 32'h1234_5678; byteenable = 4'hF; write = 1'b1; read = 1'b1;
    @(negedge clock); write = 1'b0; read = 1'b0;
    check("rw_old", readdata, 32'hDE00_BE00);
    rd(4'd3, d); check("rw_new", d, 32'h1234_5678);

    // Read-only offsets and CTRL without lane 0
    wr(4'd0, 32'h0, 4'hF);
    rd(4'd0, d); check("ro_id", d, 32'd1459509197);
    wr(4'd6, 32'h0, 4'hE);
    rd(4'd6, d); check("ctrl_no_lane0", d, 32'h1);

    // Coherent snapshot near a 2^32 boundary
    force dut.u_uptime.cnt = 64'h0000_0002_FFFF_FFF0;
    rd(4'd4, d); check("lo_forced", d, 32'hFFFF_FFF0);
    rd(4'd6, d); check("snap_valid_set", d, 32'h101);
    force dut.u_uptime.cnt = 64'h0000_0007_0000_0000;
    rd(4'd5, d); check("hi_snapshot", d, 32'h2);
    rd(4'd6, d); check("snap_valid_clr", d, 32'h1);
    release dut.u_uptime.cnt;

    // CLEAR then immediate LO read
    wr(4'd6, 32'h3, 4'h1);
    rd(4'd4, d); check("lo_after_clear", 32'(d <= 32'd3), 32'd1);
    rd(4'd5, d); check("hi_after_clear", d, 32'h0);

    // Back-to-back LO reads differ by one while running
    @(negedge clock); address = 4'd4; read = 1'b1;
    @(negedge clock); d1 = readdata;
    @(negedge clock); d2 = readdata; read = 1'b0;
    check("count_inc", d2 - d1, 32'd1);

    // RUN off holds the counter; RUN on resumes
    wr(4'd6, 32'h0, 4'h1);
    rd(4'd4, d1);
    repeat (10) @(negedge clock);
    rd(4'd4, d2); check("run_off_hold", d2, d1);
    rd(4'd6, d); check("ctrl_run_off", d, 32'h100);
    wr(4'd6, 32'h1, 4'h1);
    repeat (2) @(negedge clock);
    rd(4'd4, d); check("run_on_moves", 32'(d != d2), 32'd1);

    // User table and unmapped offsets
    rd(4'd8,  d); check("user0", d, 32'h1111_1111);
    rd(4'd9,  d); check("user1", d, 32'h2222_2222);
    rd(4'd10, d); check("user2", d, 32'h3333_3333);
    rd(4'd11, d); check("user3", d, 32'h4444_4444);
    rd(4'd12, d); check("unmapped12", d, 32'h0);
    rd(4'd15, d); check("unmapped15", d, 32'h0);

    // Reset asserted while a read response is pending
    wr(4'd6, 32'h0, 4'h1);
    @(negedge clock); address = 4'd3; read = 1'b1;
    @(posedge clock); #1;
    check("pre_reset_rdv", 32'(readdatavalid), 32'd1);
    reset = 1'b1;
    #1;
    check("reset_drop_rdv", 32'(readdatavalid), 32'd0);
    check("reset_drop_rdata", readdata, 32'h0);
    read = 1'b0;
    @(negedge clock); reset = 1'b0;
    rd(4'd3, d); check("scratch_after_reset", d, 32'h0);
    rd(4'd6, d); check("ctrl_after_reset", d, 32'h1);
    rd(4'd5, d); check("hi_after_reset", d, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
